// File: rtl/unpacker_pkg.sv
// Shared types and helpers for the packed-word unpacker.
package unpacker_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  function automatic int idx_width(input int n);
    return ($clog2(n) > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/unpacker_counter_roll.sv
// Up counter that rolls over to 0 after reaching max_val_i; 1-cycle update.
// No backpressure of its own: counts only when up_i is high.
module counter_roll #(
  parameter int width_p = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               up_i,
  input  logic [width_p-1:0] max_val_i,
  output logic [width_p-1:0] count_o
);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_o <= '0;
    end else if (up_i) begin
      count_o <= (count_o == max_val_i) ? '0 : count_o + 1'b1;
    end
  end

endmodule

// File: rtl/unpacker.sv
// Splits a packed word into num_packed_p elements, LSB first; element 0 one cycle after accept.
// Holds the current element under backpressure; takes the next word on the last element's fire.
module unpacker
  import unpacker_pkg::*;
#(
  parameter int unpacked_p   = 2,
  parameter int num_packed_p = 4
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic [unpacked_p*num_packed_p-1:0] packed_i,
  input  logic                               valid_i,
  output logic                               ready_o,
  output logic [unpacked_p-1:0]              unpacked_o,
  output logic                               valid_o,
  input  logic                               ready_i,
  output logic                               last_o
);

  localparam int width    = unpacked_p * num_packed_p;
  localparam int iw       = idx_width(num_packed_p);
  localparam logic [iw-1:0] last_idx = iw'(num_packed_p - 1);

  state_t           state;
  state_t           state_next;
  logic [width-1:0] shift;
  logic [iw-1:0]    idx;
  logic             in_fire;
  logic             out_fire;

  assign valid_o    = (state == DRAIN);
  assign unpacked_o = shift[unpacked_p-1:0];
  assign last_o     = valid_o & (idx == last_idx);
  assign out_fire   = valid_o & ready_i;
  // Opening up on the last element's fire keeps words flowing with no bubble.
  assign ready_o    = reset_i & ((state == IDLE) | (out_fire & last_o));
  assign in_fire    = valid_i & ready_o;

  counter_roll #(
    .width_p (iw)
  ) u_idx (
    .clk_i     (clk_i),
    .reset_i   (~reset_i),
    .up_i      (out_fire),
    .max_val_i (last_idx),
    .count_o   (idx)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_fire) state_next = DRAIN;
      DRAIN:   if (out_fire && last_o && !in_fire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      shift <= '0;
    end else if (in_fire) begin
      shift <= packed_i;
    end else if (out_fire) begin
      // Clearing on the final element keeps unpacked_o at zero while idle.
      shift <= last_o ? '0 : (shift >> unpacked_p);
    end
  end

endmodule

// File: tb/tb_unpacker.sv
// Directed and soak checks of unpacker at 2x4 and 3x3 element geometries.
module tb_unpacker;

  logic       clk = 1'b0;
  logic       reset_i;
  logic [7:0] packed_i;
  logic       valid_i;
  logic       ready_o;
  logic [1:0] unpacked_o;
  logic       valid_o;
  logic       ready_i;
  logic       last_o;

  logic [8:0] packed2;
  logic       valid2;
  logic       ready2_o;
  logic [2:0] unpacked2;
  logic       valid2_o;
  logic       ready2;
  logic       last2_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  unpacker #(.unpacked_p(2), .num_packed_p(4)) dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .packed_i   (packed_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .unpacked_o (unpacked_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .last_o     (last_o)
  );

  unpacker #(.unpacked_p(3), .num_packed_p(3)) dut3 (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .packed_i   (packed2),
    .valid_i    (valid2),
    .ready_o    (ready2_o),
    .unpacked_o (unpacked2),
    .valid_o    (valid2_o),
    .ready_i    (ready2),
    .last_o     (last2_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] exp_a [8];
    logic [2:0] exp3a [3];
    logic [2:0] exp3b [3];
    logic [6:0] bp;
    logic [2:0] q [$];
    logic [2:0] ent;
    int         e;
    int         fires;
    int         words;
    int         acc;
    int         cycles;
    logic       hold_v;
    logic [1:0] hold_d;
    logic       took;

    exp_a = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
    exp3a = '{3'b110, 3'b011, 3'b101};
    exp3b = '{3'd7, 3'd2, 3'd1};

    reset_i = 1'b0; packed_i = '0; valid_i = 1'b0; ready_i = 1'b1;
    packed2 = '0; valid2 = 1'b0; ready2 = 1'b1;
    tick; tick;
    check("rst_valid", valid_o, 1'b0);
    check("rst_data", unpacked_o, 2'd0);
    check("rst_last", last_o, 1'b0);
    check("rst_ready", ready_o, 1'b0);
    check("rst_ready3", ready2_o, 1'b0);

    // Single word
    reset_i = 1'b1;
    tick;
    valid_i = 1'b1; packed_i = 8'hE4;
    #1;
    check("t1_ready_idle", ready_o, 1'b1);
    tick;
    valid_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("t1_valid", valid_o, 1'b1);
      check("t1_data", unpacked_o, exp_a[k]);
      check("t1_last", last_o, k == 3);
      tick;
    end
    check("t1_idle_valid", valid_o, 1'b0);
    check("t1_idle_ready", ready_o, 1'b1);
    check("t1_idle_data", unpacked_o, 2'd0);

    // Back-to-back words
    valid_i = 1'b1; packed_i = 8'hE4;
    #1;
    check("t2_ready0", ready_o, 1'b1);
    tick;
    packed_i = 8'h1B;
    for (int k = 0; k < 8; k++) begin
      if (k == 4) valid_i = 1'b0;
      #1;
      check("t2_valid", valid_o, 1'b1);
      check("t2_data", unpacked_o, exp_a[k]);
      check("t2_last", last_o, (k % 4) == 3);
      check("t2_ready", ready_o, (k % 4) == 3);
      tick;
    end
    check("t2_end_valid", valid_o, 1'b0);

    // Backpressure
    bp = 7'b1101001;
    valid_i = 1'b1; packed_i = 8'hE4;
    tick;
    valid_i = 1'b0;
    e = 0; fires = 0;
    for (int c = 0; c < 7; c++) begin
      ready_i = bp[c];
      #1;
      check("t3_valid", valid_o, 1'b1);
      check("t3_data", unpacked_o, exp_a[e]);
      check("t3_last", last_o, e == 3);
      if (valid_o && ready_i) fires++;
      if (bp[c]) e++;
      tick;
    end
    check("t3_fires", fires, 4);
    check("t3_end_valid", valid_o, 1'b0);
    ready_i = 1'b1;

    // Reset mid-word
    valid_i = 1'b1; packed_i = 8'hE4;
    tick;
    valid_i = 1'b0;
    tick; tick;
    check("t4_before_rst", unpacked_o, 2'd2);
    reset_i = 1'b0;
    #1;
    check("t4_ready_in_rst", ready_o, 1'b0);
    tick;
    check("t4_valid_rst", valid_o, 1'b0);
    check("t4_data_rst", unpacked_o, 2'd0);
    check("t4_ready_rst", ready_o, 1'b0);
    reset_i = 1'b1;
    valid_i = 1'b1; packed_i = 8'h1B;
    #1;
    check("t4_ready_after", ready_o, 1'b1);
    tick;
    valid_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("t4_valid", valid_o, 1'b1);
      check("t4_data", unpacked_o, exp_a[4 + k]);
      check("t4_last", last_o, k == 3);
      tick;
    end
    check("t4_end_valid", valid_o, 1'b0);

    // Three-element geometry
    valid2 = 1'b1; packed2 = 9'b101_011_110;
    #1;
    check("t5_ready0", ready2_o, 1'b1);
    tick;
    packed2 = 9'b001_010_111;
    for (int k = 0; k < 6; k++) begin
      if (k == 3) valid2 = 1'b0;
      #1;
      check("t5_valid", valid2_o, 1'b1);
      check("t5_data", unpacked2, (k < 3) ? exp3a[k] : exp3b[k - 3]);
      check("t5_last", last2_o, (k % 3) == 2);
      check("t5_ready", ready2_o, (k % 3) == 2);
      tick;
    end
    check("t5_end_valid", valid2_o, 1'b0);

    // Random soak
    words = 0; acc = 0; cycles = 0; hold_v = 1'b0; hold_d = '0;
    valid_i = 1'b0;
    while ((acc < 1000 || q.size() != 0) && cycles < 30000) begin
      if (!valid_i && words < 1000 && $urandom_range(0, 3) != 0) begin
        valid_i = 1'b1;
        packed_i = 8'($urandom);
        words++;
      end
      ready_i = ($urandom_range(0, 3) != 0);
      #1;
      if (hold_v) begin
        check("soak_hold_valid", valid_o, 1'b1);
        check("soak_hold_data", unpacked_o, hold_d);
      end
      if (!valid_o) begin
        check("soak_idle_data", unpacked_o, 2'd0);
        check("soak_idle_last", last_o, 1'b0);
      end
      if (valid_o && ready_i) begin
        if (q.size() == 0) begin
          check("soak_extra_elem", 1, 0);
        end else begin
          ent = q.pop_front();
          check("soak_data", unpacked_o, ent[1:0]);
          check("soak_last", last_o, ent[2]);
        end
      end
      took = valid_i && ready_o;
      if (took) begin
        for (int k = 0; k < 4; k++) q.push_back({k == 3, packed_i[k*2 +: 2]});
        acc++;
      end
      hold_v = valid_o && !ready_i;
      hold_d = unpacked_o;
      tick;
      cycles++;
      if (took) valid_i = 1'b0;
    end
    check("soak_timeout", cycles < 30000, 1);
    check("soak_accepted", acc, 1000);
    check("soak_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/unpacker.md
Name: unpacker

Overview:
Serialises wide packed words into a stream of narrow elements, lowest-order element first, using valid/ready handshakes on both sides. It is the receive-side counterpart of the pixel packer. It splits each unpacked_p*num_packed_p-bit word back into num_packed_p elements of unpacked_p bits for the downstream pixel pipeline. At most one word is buffered, and it sustains one element per cycle across word boundaries.

Parameters:
unpacked_p, 2, width in bits of each output element
num_packed_p, 4, elements per packed word; legal values >= 2, not necessarily a power of two

Ports:
clk_i  input  1  single clock; all state updates on rising edge
reset_i  input  1  synchronous, active-low reset; asserted when 0, sampled on clk_i rising edge
packed_i  input  unpacked_p*num_packed_p  packed word; element k at bits [k*unpacked_p +: unpacked_p]
valid_i  input  1  packed_i valid
ready_o  output  1  unpacker can accept a packed word this cycle
unpacked_o  output  unpacked_p  current element
valid_o  output  1  unpacked_o valid
ready_i  input  1  downstream accepts unpacked_o
last_o  output  1  current element is element num_packed_p-1 of its word; qualified by valid_o

Behaviour:
- Fire definitions: in_fire = valid_i & ready_o; out_fire = valid_o & ready_i.
- States:
  - IDLE: no word held.
  - DRAIN: word held in shift_r; element index idx_r is in 0..num_packed_p-1.
- Index counter width is max(1, $clog2(num_packed_p)). Wrap is explicit at num_packed_p-1; there is no reliance on natural overflow.
- Outputs are driven from registers:
  - valid_o = (state==DRAIN).
  - unpacked_o = shift_r[unpacked_p-1:0].
  - last_o = (state==DRAIN) & (idx_r==num_packed_p-1).
- ready_o = reset_i & ((state==IDLE) | (out_fire & last_o)). This is a combinational path from ready_i to ready_o on the last element, and it is required for zero-bubble throughput.
- IDLE, on in_fire: shift_r <= packed_i, idx_r <= 0, go to DRAIN.
- DRAIN, out_fire with !last_o: shift_r <= shift_r >> unpacked_p, idx_r <= idx_r+1.
- DRAIN, out_fire with last_o:
  - If in_fire in the same cycle: load the new word and set idx_r <= 0; stay in DRAIN.
  - Otherwise: clear shift_r to 0, set idx_r <= 0, go to IDLE.
- DRAIN with !ready_i: shift_r, idx_r, unpacked_o and last_o hold stable. valid_o is never withdrawn without out_fire.
- Latency: word accepted in cycle N gives element 0 valid in cycle N+1 and element k in cycle N+1+k under continuous ready_i.
- Throughput: num_packed_p elements every num_packed_p cycles under continuous valid_i/ready_i, with no bubbles.
- When valid_o=0, unpacked_o reads 0 (datapath reset and clear on drain).
- Reset values (reset_i==0): state=IDLE, valid_o=0, last_o=0, unpacked_o=0, idx_r=0, ready_o=0 while reset is asserted.
- Reset mid-word: the partial word is discarded with no further elements emitted. ready_o=1 on the first cycle after reset_i returns to 1.
- valid_i while ready_o=0: packed_i is ignored; the upstream source must hold it.

Decomposition:
- unpacker_pkg:
  - state enum typedef (IDLE, DRAIN);
  - function idx_width(n) returning max(1, $clog2(n)).
- Index counter reuses the existing counter_roll block:
  - up_i = out_fire;
  - max_val_i = num_packed_p-1;
  - reset driven by the inverted reset_i.
- Shift register and FSM stay in unpacker; no other sub-module.

Test Plan:
1. Defaults, ready_i=1, single word packed_i=8'hE4 -> unpacked_o = 0,1,2,3 on consecutive cycles starting 1 cycle after accept; last_o only with value 3; then valid_o=0, ready_o=1.
2. Back-to-back words 8'hE4 then 8'h1B, valid_i held high -> 8 elements 0,1,2,3,3,2,1,0 with no gap; second word accepted in the cycle element 3 fires; ready_o low on the 3 middle cycles of each word.
3. Backpressure: word 8'hE4, ready_i toggling 1,0,0,1,0,1,1 -> each element held stable while ready_i=0; order 0,1,2,3 preserved; exactly 4 out_fires, last_o on the 4th.
4. Reset mid-word: accept 8'hE4, take 2 elements, drive reset_i=0 for 1 cycle -> valid_o=0, unpacked_o=0, ready_o=0 during reset; ready_o=1 after; next word 8'h1B yields 3,2,1,0.
5. unpacked_p=3, num_packed_p=3, packed_i=9'b101_011_110 -> elements 3'b110, 3'b011, 3'b101; index wraps at 2, not 3.
6. Random soak, 1000 words, random valid_i/ready_i -> scoreboard element stream equals LSB-first split of accepted words; last_o every num_packed_p-th element; valid_o never drops without out_fire.
